// File: rtl/div_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_16by8_seq
// Brief    : Sequential restoring divider, 16-bit / 8-bit -> 8-bit q + 8-bit r,
//            one quotient bit per cycle with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module div_16by8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  pr_q;
    logic [7:0]  qr_q;
    logic [7:0]  d_q;
    logic [2:0]  count_q;
    logic [7:0]  quotient_q;
    logic [7:0]  remainder_q;
    logic        ovf_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [8:0]  w_shift;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic [7:0]  pr_d;
    logic [7:0]  qr_d;

    // The partial remainder always stays below the divisor, so only the shifted
    // trial value needs the ninth bit; the difference then fits in 8 bits.
    assign w_shift = {pr_q, qr_q[7]};
    assign w_ge    = (w_shift >= {1'b0, d_q});
    assign w_diff  = w_shift[7:0] - d_q;
    assign pr_d    = w_ge ? w_diff : w_shift[7:0];
    assign qr_d    = {qr_q[6:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pr_q        <= 8'd0;
            qr_q        <= 8'd0;
            d_q         <= 8'd0;
            count_q     <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 8'd0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        d_q        <= divisor;
                        in_ready_q <= 1'b0;
                        if ((divisor == 8'd0) || (dividend[15:8] >= divisor)) begin
                            ovf_q       <= 1'b1;
                            quotient_q  <= 8'hFF;
                            remainder_q <= 8'h00;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            pr_q    <= dividend[15:8];
                            qr_q    <= dividend[7:0];
                            count_q <= 3'd0;
                            ovf_q   <= 1'b0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    pr_q    <= pr_d;
                    qr_q    <= qr_d;
                    count_q <= count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        quotient_q  <= qr_d;
                        remainder_q <= pr_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result registers keep their values after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_div_16by8_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_16by8_seq
// Brief    : Self-checking bench for div_16by8_seq: directed literal cases plus
//            randomized traffic scored against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_16by8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    bit prod_done = 1'b0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        o;
    } exp_t;

    exp_t sb[$];

    div_16by8_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int unsigned qi;
        e.a = a;
        e.b = b;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = 8'h00; e.o = 1'b1;
        end else begin
            qi = int'(a) / int'(b);
            if (qi > 255) begin
                e.q = 8'hFF; e.r = 8'h00; e.o = 1'b1;
            end else begin
                e.q = 8'(qi);
                e.r = 8'(int'(a) % int'(b));
                e.o = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Scoreboard bookkeeping on the active edge (pre-edge values are visible here).
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back(model(dividend, divisor));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=out_valid required=no_result t=%0t", $time);
            end else begin
                e = sb[0];
                check("sb_result", {quotient, remainder, ovf}, {e.q, e.r, e.o});
                if (!e.o)
                    check("sb_invariant",
                          32'((int'(quotient) * int'(e.b) + int'(remainder) == int'(e.a))
                              && (remainder < e.b)), 32'd1);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [7:0] b);
        int n = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic directed(input logic [15:0] a, input logic [7:0] b, input logic [7:0] q,
                            input logic [7:0] r, input logic o, input int hold);
        int lat = 0;
        out_ready = 1'b0;
        send(a, b);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), o ? 32'd0 : 32'd8);
        check("quotient", {24'd0, quotient}, {24'd0, q});
        check("remainder", {24'd0, remainder}, {24'd0, r});
        check("ovf", {31'd0, ovf}, {31'd0, o});
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold", {out_valid, in_ready, quotient, remainder, ovf}, {2'b10, q, r, o});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release", {out_valid, in_ready, quotient, remainder, ovf}, {2'b01, q, r, o});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] hi;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, quotient, remainder, ovf}, {2'b10, 17'd0});
        rst = 1'b0;

        directed(16'd1000, 8'd7,   8'd142, 8'd6,  1'b0, 0);
        directed(16'hFEFF, 8'hFF,  8'hFF,  8'hFE, 1'b0, 0);
        directed(16'hFF00, 8'hFF,  8'hFF,  8'h00, 1'b1, 0);
        directed(16'h1234, 8'h00,  8'hFF,  8'h00, 1'b1, 0);
        directed(16'd77,   8'd7,   8'd11,  8'd0,  1'b0, 5);

        // Abort an operation mid-calculation; nothing may come out of it.
        send(16'd1000, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset", {in_ready, out_valid, quotient, remainder, ovf}, {2'b10, 17'd0});
        repeat (12) begin @(posedge clk); #1; end
        check("mid_reset_quiet", {31'd0, out_valid}, 32'd0);
        directed(16'd500, 8'd9, 8'd55, 8'd5, 1'b0, 1);

        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    b = 8'($urandom);
                    if ($urandom_range(0, 3) == 0 || b == 8'd0) hi = 8'($urandom);
                    else hi = 8'($urandom_range(0, int'(b) - 1));
                    if ($urandom_range(0, 31) == 0) b = 8'd0;
                    send({hi, 8'($urandom)}, b);
                end
                prod_done = 1'b1;
            end
            begin
                int guard = 0;
                while ((!prod_done || sb.size() > 0) && guard < 90000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                    guard++;
                end
                out_ready = 1'b0;
            end
        join
        check("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
